// File: rtl/pmu_pkg.sv
// Shared definitions for the configuration-chain loader: FSM states and
// word/preset geometry.
package pmu_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned PRESET_CYCLES = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESET = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } ccff_state_e;

  function automatic logic is_busy(input ccff_state_e s);
    return !(s inside {ST_IDLE, ST_DONE, ST_ERROR});
  endfunction

endpackage

// File: rtl/ccff_bit_timer.sv
// Per-bit programming-clock timer: PROG_DIV cycles low, PROG_DIV cycles high,
// with a strobe on the last cycle of each bit period.
module ccff_bit_timer #(
  parameter int unsigned PROG_DIV = 2
) (
  input  logic tck_i,
  input  logic rst_i,
  input  logic active_i,   // currently in SHIFT
  input  logic run_i,      // remains in SHIFT next cycle
  output logic progclk_o,
  output logic bit_done_o
);

  localparam int unsigned PERIOD = 2 * PROG_DIV;
  localparam int unsigned CNT_W  = $clog2(PERIOD);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(PROG_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             progclk_q, progclk_d;

  assign bit_done_o = active_i && (cnt_q == LAST);
  assign progclk_o  = progclk_q;

  // The counter restarts at zero whenever SHIFT is (re)entered, so the
  // registered clock is computed from the next count value.
  always_comb begin
    cnt_d = '0;
    if (run_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
    progclk_d = (cnt_d >= HALF);
  end

  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      progclk_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      progclk_q <= progclk_d;
    end
  end

endmodule

// File: rtl/ccff_loader.sv
// Configuration-chain loader: takes 32-bit words from the decrypt path and
// shifts them MSB first into the FPGA configuration chain.
module ccff_loader
  import pmu_pkg::*;
#(
  parameter int unsigned CHAIN_LEN    = 1024,
  parameter int unsigned PROG_DIV     = 2,
  parameter int unsigned WORD_TIMEOUT = 4096
) (
  input  logic        tck_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] word_i,
  input  logic        word_valid_i,
  output logic        word_ready_o,
  output logic        data_o,
  output logic        progclk_o,
  output logic        config_enable_o,
  output logic        preset_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [15:0] bit_count_o
);

  localparam int unsigned PC_W  = $clog2(PRESET_CYCLES);
  localparam int unsigned TMO_W = $clog2(WORD_TIMEOUT + 1);
  localparam int unsigned IDX_W = $clog2(WORD_W);

  ccff_state_e         state_q, state_d;
  logic [PC_W-1:0]     preset_cnt_q, preset_cnt_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [WORD_W-1:0]   sreg_q, sreg_d;
  logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic [15:0]         bit_count_q, bit_count_d;

  logic word_ready_q, word_ready_d;
  logic data_q, data_d;
  logic cfg_en_q, cfg_en_d;
  logic preset_q, preset_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic error_q, error_d;

  logic accept;
  logic bit_done;
  logic timer_active;
  logic timer_run;

  assign accept       = word_ready_q && word_valid_i;
  assign timer_active = (state_q == ST_SHIFT);
  assign timer_run    = (state_q == ST_SHIFT) && (state_d == ST_SHIFT);

  ccff_bit_timer #(
    .PROG_DIV (PROG_DIV)
  ) u_bit_timer (
    .tck_i      (tck_i),
    .rst_i      (rst_i),
    .active_i   (timer_active),
    .run_i      (timer_run),
    .progclk_o  (progclk_o),
    .bit_done_o (bit_done)
  );

  always_comb begin
    state_d      = state_q;
    preset_cnt_d = preset_cnt_q;
    tmo_d        = tmo_q;
    sreg_d       = sreg_q;
    bit_idx_d    = bit_idx_q;
    bit_count_d  = bit_count_q;

    if (abort_i) begin
      state_d      = ST_IDLE;
      preset_cnt_d = '0;
      tmo_d        = '0;
      sreg_d       = '0;
      bit_idx_d    = '0;
      bit_count_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start_i) begin
            state_d      = ST_PRESET;
            preset_cnt_d = '0;
            tmo_d        = '0;
            sreg_d       = '0;
            bit_idx_d    = '0;
            bit_count_d  = '0;
          end
        end
        ST_PRESET: begin
          if (preset_cnt_q == PC_W'(PRESET_CYCLES - 1)) begin
            state_d = ST_LOAD;
            tmo_d   = '0;
          end else begin
            preset_cnt_d = preset_cnt_q + 1'b1;
          end
        end
        ST_LOAD: begin
          // An accept in the final timeout cycle still wins over ERROR.
          if (accept) begin
            state_d   = ST_SHIFT;
            sreg_d    = word_i;
            bit_idx_d = '0;
          end else if (tmo_q == TMO_W'(WORD_TIMEOUT - 1)) begin
            state_d = ST_ERROR;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (bit_done) begin
            sreg_d      = {sreg_q[WORD_W-2:0], 1'b0};
            bit_count_d = bit_count_q + 16'd1;
            bit_idx_d   = bit_idx_q + 1'b1;
            if (bit_count_d == 16'(CHAIN_LEN)) begin
              state_d = ST_DONE;
            end else if (bit_idx_q == IDX_W'(WORD_W - 1)) begin
              state_d = ST_LOAD;
              tmo_d   = '0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs are registered from the next state so they line up with it.
    word_ready_d = (state_d == ST_LOAD);
    cfg_en_d     = state_d inside {ST_PRESET, ST_LOAD, ST_SHIFT};
    preset_d     = (state_d == ST_PRESET);
    busy_d       = is_busy(state_d);
    done_d       = (state_d == ST_DONE);
    error_d      = (state_d == ST_ERROR);
    data_d       = (state_d == ST_SHIFT) && sreg_d[WORD_W-1];
  end

  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      preset_cnt_q <= '0;
      tmo_q        <= '0;
      sreg_q       <= '0;
      bit_idx_q    <= '0;
      bit_count_q  <= '0;
      word_ready_q <= 1'b0;
      data_q       <= 1'b0;
      cfg_en_q     <= 1'b0;
      preset_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      preset_cnt_q <= preset_cnt_d;
      tmo_q        <= tmo_d;
      sreg_q       <= sreg_d;
      bit_idx_q    <= bit_idx_d;
      bit_count_q  <= bit_count_d;
      word_ready_q <= word_ready_d;
      data_q       <= data_d;
      cfg_en_q     <= cfg_en_d;
      preset_q     <= preset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign word_ready_o    = word_ready_q;
  assign data_o          = data_q;
  assign config_enable_o = cfg_en_q;
  assign preset_o        = preset_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign error_o         = error_q;
  assign bit_count_o     = bit_count_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Randomized self-checking bench for ccff_loader against a transaction-level
// model of the expected chain bit stream and end state.
module tb_ccff_loader;

  localparam int unsigned CL  = 40;
  localparam int unsigned PD  = 1;
  localparam int unsigned TMO = 16;

  logic        tck;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] word;
  logic        valid;
  logic        word_ready_o;
  logic        data_o;
  logic        progclk_o;
  logic        config_enable_o;
  logic        preset_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [15:0] bit_count_o;
  logic [23:0] outs;

  int unsigned n_checks;
  int unsigned n_fail;
  int unsigned viol;

  logic [31:0] words_a [2];
  int unsigned dly_a [2];
  logic        exp_q [$];
  logic        got_q [$];

  ccff_loader #(
    .CHAIN_LEN    (CL),
    .PROG_DIV     (PD),
    .WORD_TIMEOUT (TMO)
  ) dut (
    .tck_i           (tck),
    .rst_i           (rst),
    .start_i         (start),
    .abort_i         (abort),
    .word_i          (word),
    .word_valid_i    (valid),
    .word_ready_o    (word_ready_o),
    .data_o          (data_o),
    .progclk_o       (progclk_o),
    .config_enable_o (config_enable_o),
    .preset_o        (preset_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .error_o         (error_o),
    .bit_count_o     (bit_count_o)
  );

  assign outs = {word_ready_o, data_o, progclk_o, config_enable_o, preset_o,
                 busy_o, done_o, error_o, bit_count_o};

  initial tck = 1'b0;
  always #5 tck = ~tck;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full load: drives start, answers LOAD with planned words/delays,
  // optionally aborts at a given bit count, then checks against the model.
  task automatic do_load(input string tag, input int abort_bit, input int poke_cyc);
    int cyc, widx, waitc, load_start, err_cyc, preset_n, ready_cyc, mism;
    bit prev_pc, prev_data, prev_ready, fin, exp_err;
    got_q.delete();
    @(negedge tck); start = 1'b1;
    @(negedge tck); start = 1'b0;
    cyc = 1;
    check({tag, "_bc_clr"}, 64'(bit_count_o), 64'd0);
    widx = 0; waitc = 0; preset_n = 0; ready_cyc = -1; load_start = -1; err_cyc = -1;
    prev_pc = 0; prev_data = 0; prev_ready = 0; fin = 0;
    while (!fin && cyc < 400) begin
      if (preset_o) preset_n++;
      if (word_ready_o && ready_cyc < 0) ready_cyc = cyc;
      if (word_ready_o && !prev_ready) load_start = cyc;
      if (progclk_o && !prev_pc) begin
        got_q.push_back(data_o);
        if (data_o !== prev_data) viol++;
      end
      if (!config_enable_o && (progclk_o || data_o)) viol++;
      if (error_o && err_cyc < 0) err_cyc = cyc;
      prev_pc = progclk_o; prev_data = data_o; prev_ready = word_ready_o;
      if (done_o || error_o) fin = 1;
      if (abort_bit >= 0 && int'(bit_count_o) == abort_bit && busy_o && !word_ready_o && !preset_o) begin
        valid = 1'b0; start = 1'b0; abort = 1'b1;
        @(negedge tck); abort = 1'b0;
        check({tag, "_abort_outs"}, 64'(outs), 64'd0);
        return;
      end
      if (!fin) begin
        start = (cyc == poke_cyc) && busy_o;
        valid = 1'b0;
        if (word_ready_o && widx < 2) begin
          if (waitc == int'(dly_a[widx])) begin
            valid = 1'b1; word = words_a[widx]; widx++; waitc = 0;
          end else begin
            waitc++;
          end
        end
        @(negedge tck);
        cyc++;
      end
    end
    start = 1'b0; valid = 1'b0;
    check({tag, "_term"}, 64'(fin), 64'd1);

    exp_q.delete();
    exp_err = 0;
    for (int w = 0; w < 2; w++) begin
      if (exp_q.size() >= CL) break;
      if (dly_a[w] >= TMO) begin exp_err = 1; break; end
      for (int b = 31; b >= 0; b--)
        if (exp_q.size() < CL) exp_q.push_back(words_a[w][b]);
    end
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;

    check({tag, "_preset_len"}, 64'(preset_n), 64'd4);
    check({tag, "_ready_cyc"}, 64'(ready_cyc), 64'd5);
    check({tag, "_done"}, 64'(done_o), 64'(!exp_err));
    check({tag, "_error"}, 64'(error_o), 64'(exp_err));
    check({tag, "_bit_count"}, 64'(bit_count_o), 64'(exp_q.size()));
    check({tag, "_nbits"}, 64'(got_q.size()), 64'(exp_q.size()));
    check({tag, "_bits"}, 64'(mism), 64'd0);
    check({tag, "_idle_pins"}, 64'({config_enable_o, busy_o, progclk_o, data_o, word_ready_o}), 64'd0);
    if (exp_err) check({tag, "_tmo_cycles"}, 64'(err_cyc - load_start), 64'(TMO));
  endtask

  initial begin
    n_checks = 0; n_fail = 0; viol = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; valid = 1'b0; word = '0;
    #12;
    check("reset_outs", 64'(outs), 64'd0);
    @(negedge tck); rst = 1'b0;
    @(negedge tck);
    check("idle_outs", 64'(outs), 64'd0);

    words_a[0] = 32'hA5A5A5A5; words_a[1] = 32'hFFFF0000;
    dly_a[0] = 0; dly_a[1] = 0;
    do_load("chain40", -1, -1);

    dly_a[0] = 16; dly_a[1] = 0;
    do_load("tmo_w0", -1, -1);

    words_a[0] = 32'h12345678;
    dly_a[0] = 3; dly_a[1] = 16;
    do_load("tmo_w1", -1, -1);
    repeat (3) @(negedge tck);
    check("err_hold_bc", 64'(bit_count_o), 64'd32);
    check("err_hold_flag", 64'({error_o, config_enable_o}), 64'b10);

    words_a[1] = 32'hCAFEF00D;
    dly_a[0] = 15; dly_a[1] = 15;
    do_load("tmo_edge_poke", -1, 8);

    dly_a[0] = 0; dly_a[1] = 0;
    do_load("abort", 10, -1);
    do_load("after_abort", -1, -1);

    // Reset between edges while the programming clock is high.
    @(negedge tck); start = 1'b1;
    @(negedge tck); start = 1'b0;
    for (int i = 0; i < 60 && !progclk_o; i++) begin
      valid = word_ready_o; word = 32'h0F0F0F0F;
      @(negedge tck);
    end
    valid = 1'b0;
    check("pre_rst_pc", 64'({progclk_o, config_enable_o}), 64'b11);
    #1 rst = 1'b1;
    #1;
    check("async_rst_pins", 64'({progclk_o, config_enable_o}), 64'd0);
    check("async_rst_outs", 64'(outs), 64'd0);
    @(negedge tck); rst = 1'b0;

    for (int n = 0; n < 12; n++) begin
      words_a[0] = $urandom; words_a[1] = $urandom;
      for (int w = 0; w < 2; w++) begin
        dly_a[w] = $urandom_range(0, 9);
        if ($urandom_range(0, 4) == 0) dly_a[w] = $urandom_range(13, 17);
      end
      do_load($sformatf("rnd%0d", n), -1, int'($urandom_range(1, 80)));
    end

    check("invariants", 64'(viol), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 1024, giving the total configuration-chain bits shifted per load (range 1..65535).
REQ-002 SHALL have parameter PROG_DIV, default 2, giving the tck_i cycles per progclk_o phase (range 1..255).
REQ-003 SHALL have parameter WORD_TIMEOUT, default 4096, giving the maximum tck_i cycles spent waiting in LOAD.
REQ-004 SHALL have port tck_i, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port start_i, input, 1 bit: single-cycle request to begin a load.
REQ-007 SHALL have port abort_i, input, 1 bit: synchronous cancel.
REQ-008 SHALL have port word_i, input, 32 bits: decrypted bitstream word from the AES read path.
REQ-009 SHALL have port word_valid_i, input, 1 bit: word_i valid.
REQ-010 SHALL have port word_ready_o, output, 1 bit: loader accepts word_i this cycle.
REQ-011 SHALL have port data_o, output, 1 bit: serial chain head data.
REQ-012 SHALL have port progclk_o, output, 1 bit: chain programming clock.
REQ-013 SHALL have port config_enable_o, output, 1 bit: FPGA configuration enable.
REQ-014 SHALL have port preset_o, output, 1 bit: chain preset pulse.
REQ-015 SHALL have port busy_o, output, 1 bit: state is neither IDLE, DONE nor ERROR.
REQ-016 SHALL have port done_o, output, 1 bit: high while in DONE.
REQ-017 SHALL have port error_o, output, 1 bit: high while in ERROR.
REQ-018 SHALL have port bit_count_o, output, 16 bits: bits shifted so far in the current load.

Function
REQ-019 FSM states SHALL be IDLE, PRESET, LOAD, SHIFT, DONE, ERROR.
REQ-020 IDLE/DONE/ERROR: start_i SHALL go to PRESET next cycle and clear bit_count_o, the timeout counter, done_o and error_o.
REQ-021 PRESET: preset_o=1 and config_enable_o=1 for exactly 4 cycles, then LOAD.
REQ-022 config_enable_o SHALL be 1 in PRESET, LOAD and SHIFT only.
REQ-023 LOAD: word_ready_o=1; it SHALL be 0 in every other state.
REQ-024 On word_valid_i & word_ready_o, the loader SHALL latch word_i into a 32-bit shift register, reset bit index and phase counter, and enter SHIFT next cycle.
REQ-025 SHIFT: data_o SHALL be shift register bit 31 (MSB first), valid from the first SHIFT cycle.
REQ-026 Each bit SHALL take 2*PROG_DIV cycles: PROG_DIV cycles with progclk_o=0, then PROG_DIV cycles with progclk_o=1; data_o SHALL be stable across the whole bit.
REQ-027 At the end of each bit period, bit_count_o SHALL increment and the shift register SHALL shift left by one.
REQ-028 When bit_count_o reaches CHAIN_LEN, the FSM SHALL go to DONE; any remaining bits of the current word SHALL be discarded.
REQ-029 Otherwise, after the 32nd bit of a word, the FSM SHALL go to LOAD.
REQ-030 The LOAD timeout counter SHALL clear on entry to LOAD; if it reaches WORD_TIMEOUT with no accept, the FSM SHALL go to ERROR.
REQ-031 A word accepted in the same cycle the timeout expires SHALL win: the FSM goes to SHIFT, not ERROR.
REQ-032 abort_i in any state SHALL go to IDLE next cycle with all outputs at reset values; abort_i SHALL have priority over start_i.
REQ-033 start_i while busy_o=1 SHALL be ignored.
REQ-034 progclk_o and data_o SHALL be 0 outside SHIFT.
REQ-035 bit_count_o SHALL hold its value in DONE and ERROR.

Reset
REQ-036 rst_i asserted SHALL immediately force IDLE, with every output 0, bit_count_o=0, and the shift register and counters cleared.
REQ-037 rst_i asserted mid-SHIFT SHALL drop config_enable_o and progclk_o asynchronously.

Structure
REQ-038 The FSM state enum, WORD_W=32 and PRESET_CYCLES=4 SHALL live in shared package pmu_pkg.
REQ-039 The progclk phase/bit timing SHALL be a single sub-module, ccff_bit_timer, emitting progclk_o and a bit_done strobe.
REQ-040 All outputs SHALL be registered.

Verification
REQ-041 CHAIN_LEN=40, PROG_DIV=1, words 0xA5A5A5A5 then 0xFFFF0000 -> data_o sequence 10100101... for 32 bits, then 8 ones; 40 progclk_o rising edges; DONE with bit_count_o=40.
REQ-042 start_i pulse -> preset_o high for exactly 4 cycles, config_enable_o rising in the same cycle, word_ready_o rising on cycle 5.
REQ-043 WORD_TIMEOUT=16, word_valid_i held 0 -> error_o=1 exactly 16 cycles after LOAD entry, config_enable_o=0, bit_count_o held.
REQ-044 abort_i during SHIFT at bit 10 -> IDLE next cycle, all outputs 0; a later start_i restarts with bit_count_o=0.
REQ-045 rst_i pulsed mid-bit, between clock edges -> progclk_o and config_enable_o low before the next tck_i edge.
REQ-046 start_i while busy, plus word accept coinciding with timeout expiry -> start_i ignored, FSM enters SHIFT, error_o stays 0.
